// File: rtl/led_display_arbiter.sv
// led_display_arbiter: round-robin owner of the 8-digit 7-segment display.
// Two requesters compete for the display. Ownership changes only at frame
// boundaries, and an owner keeps the display for a minimum number of frames
// while the other side is waiting. The owner's digits, blanks and decimal
// points are latched once per frame. They are scanned 7..0 onto the
// active-low display pins.
module led_display_arbiter #(
  parameter int SCAN_CYC    = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [7:0]  blank0,
  input  logic [7:0]  blank1,
  input  logic [7:0]  dp0,
  input  logic [7:0]  dp1,
  output logic [1:0]  gnt,
  output logic        frame_tick,
  output logic [7:0]  led_en,
  output logic        led_ca,
  output logic        led_cb,
  output logic        led_cc,
  output logic        led_cd,
  output logic        led_ce,
  output logic        led_cf,
  output logic        led_cg,
  output logic        led_dp
);

  localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int FW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);
  localparam logic [FW-1:0] HOLD_MAX  = FW'(HOLD_FRAMES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // Hex nibble to {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Frame counter increment that sticks at the hold limit.
  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] c);
    return (c >= HOLD_MAX) ? HOLD_MAX : c + 1'b1;
  endfunction

  // Arbitration and scan state (control, reset).
  logic [1:0]    state, state_n;
  logic          rr, rr_n;
  logic [2:0]    digit, digit_n;
  logic [SW-1:0] scan, scan_n;
  logic [FW-1:0] fcnt, fcnt_n, fcnt_inc;

  // Frame shadow registers (data, not reset).
  logic [31:0] shadow_data;
  logic [7:0]  shadow_blank;
  logic [7:0]  shadow_dp;

  logic load;
  logic sel;
  logic owner;
  logic frame_end;

  // Output stage: p0 is next-cycle pin content, p1 is registered.
  logic        vld_p0, vld_p1;
  logic [7:0]  en_p0, en_p1;
  logic [6:0]  seg_p0, seg_p1;
  logic        dp_p0, dp_p1;
  logic [31:0] src_data;
  logic [7:0]  src_blank;
  logic [7:0]  src_dp;

  assign owner     = (state == OWN1);
  assign frame_end = (state != IDLE) && (digit == 3'd0) && (scan == SCAN_LAST);
  assign fcnt_inc  = sat_inc(fcnt);

  // Arbitration: grant from idle, scan advance, frame-end handover decision.
  always_comb begin
    state_n = state;
    rr_n    = rr;
    digit_n = digit;
    scan_n  = scan;
    fcnt_n  = fcnt;
    load    = 1'b0;
    sel     = owner;
    if (state == IDLE) begin
      if (req != 2'b00) begin
        sel     = (req == 2'b11) ? rr : req[1];
        load    = 1'b1;
        state_n = sel ? OWN1 : OWN0;
        rr_n    = ~sel;
        digit_n = 3'd7;
        scan_n  = '0;
        fcnt_n  = '0;
      end
    end else if (frame_end) begin
      digit_n = 3'd7;
      scan_n  = '0;
      if (!req[owner] && !req[~owner]) begin
        state_n = IDLE;
        fcnt_n  = '0;
      end else if (req[~owner] && (!req[owner] || fcnt_inc >= HOLD_MAX)) begin
        // Hand over to the waiting side; the old owner becomes favoured next.
        sel     = ~owner;
        load    = 1'b1;
        state_n = sel ? OWN1 : OWN0;
        rr_n    = owner;
        fcnt_n  = '0;
      end else begin
        // Keep the owner and pick up its fresh inputs for the next frame.
        sel     = owner;
        load    = 1'b1;
        fcnt_n  = fcnt_inc;
      end
    end else if (scan == SCAN_LAST) begin
      scan_n  = '0;
      digit_n = digit - 3'd1;
    end else begin
      scan_n  = scan + 1'b1;
    end
  end

  // Pin content for the next cycle; a fresh latch bypasses the shadow copy.
  always_comb begin
    src_data  = load ? (sel ? data1 : data0)   : shadow_data;
    src_blank = load ? (sel ? blank1 : blank0) : shadow_blank;
    src_dp    = load ? (sel ? dp1 : dp0)       : shadow_dp;
    vld_p0    = (state_n != IDLE);
    en_p0     = ~(8'b1 << digit_n);
    seg_p0    = src_blank[digit_n] ? 7'h7f : hex7(src_data[{digit_n, 2'b00} +: 4]);
    dp_p0     = ~src_dp[digit_n];
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr     <= 1'b0;
      digit  <= 3'd7;
      scan   <= '0;
      fcnt   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_n;
      rr     <= rr_n;
      digit  <= digit_n;
      scan   <= scan_n;
      fcnt   <= fcnt_n;
      vld_p1 <= vld_p0;
    end
  end

  // Frame latch and pin data registers; outputs are gated by vld_p1.
  always_ff @(posedge clk) begin
    if (load) begin
      shadow_data  <= src_data;
      shadow_blank <= src_blank;
      shadow_dp    <= src_dp;
    end
    en_p1  <= en_p0;
    seg_p1 <= seg_p0;
    dp_p1  <= dp_p0;
  end

  // ---- stage p1: display pins ----
  assign gnt        = {state == OWN1, state == OWN0};
  assign frame_tick = frame_end;
  assign led_en     = vld_p1 ? en_p1 : 8'hff;
  assign {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = vld_p1 ? seg_p1 : 7'h7f;
  assign led_dp     = vld_p1 ? dp_p1 : 1'b1;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Scoreboard bench for led_display_arbiter. The driver drives inputs for
// each edge. A frame-level reference model then pushes the pin state it
// expects after that edge. A negedge monitor pops the expectation and
// compares it against the DUT.
module tb_led_display_arbiter;

  localparam int SCAN = 4;
  localparam int HOLD = 2;
  localparam int FLEN = 8 * SCAN;
  localparam logic [18:0] IDLE_OUT = {2'b00, 1'b0, 8'hff, 7'h7f, 1'b1};

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] data0, data1;
  logic [7:0]  blank0, blank1, dp0, dp1;
  logic [1:0]  gnt;
  logic        frame_tick;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

  led_display_arbiter #(.SCAN_CYC(SCAN), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1),
    .blank0(blank0), .blank1(blank1),
    .dp0(dp0), .dp1(dp1),
    .gnt(gnt), .frame_tick(frame_tick), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hex glyphs {g,f,e,d,c,b,a}, active low.
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Packed expectation: {gnt, frame_tick, led_en, {g..a}, led_dp}.
  logic [18:0] exp_q [$];
  logic [18:0] play [$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Model state: owner (-1 = nobody), favoured requester, completed frames.
  int owner = -1;
  int rr = 0;
  int done = 0;

  // Queue up one whole frame of pin states for requester i from current inputs.
  task automatic build_frame(input int i);
    logic [31:0] d;
    logic [7:0]  b, p, en;
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic [1:0]  g;
    d = (i == 1) ? data1 : data0;
    b = (i == 1) ? blank1 : blank0;
    p = (i == 1) ? dp1 : dp0;
    g = (i == 1) ? 2'b10 : 2'b01;
    play.delete();
    for (int k = 7; k >= 0; k--) begin
      for (int c = 0; c < SCAN; c++) begin
        en = 8'hff;
        en[k] = 1'b0;
        nib = d[4*k +: 4];
        seg = b[k] ? 7'h7f : hex_tab[nib];
        play.push_back({g, (k == 0 && c == SCAN - 1), en, seg, ~p[k]});
      end
    end
  endtask

  task automatic grant(input int i);
    owner = i;
    rr = 1 - i;
    done = 0;
    build_frame(i);
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    int o, x;
    if (rst) begin
      owner = -1;
      rr = 0;
      done = 0;
      play.delete();
    end else if (owner >= 0 && play.size() == 0) begin
      done = (done + 1 > HOLD) ? HOLD : done + 1;
      o = owner;
      x = 1 - owner;
      if (!req[o] && req[x]) grant(x);
      else if (!req[o] && !req[x]) owner = -1;
      else if (req[x] && done >= HOLD) grant(x);
      else build_frame(o);
    end else if (owner < 0 && req != 2'b00) begin
      grant((req == 2'b11) ? rr : (req[1] ? 1 : 0));
    end
    if (owner < 0) exp_q.push_back(IDLE_OUT);
    else exp_q.push_back(play.pop_front());
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every cycle's pins against the scoreboard.
  always @(negedge clk) begin
    logic [18:0] e, a;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, frame_tick, led_en, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca, led_dp};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pins cycle %0d: got gnt=%b tick=%b en=%h seg=%b dp=%b, want gnt=%b tick=%b en=%h seg=%b dp=%b",
                 cyc_no, a[18:17], a[16], a[15:8], a[7:1], a[0],
                 e[18:17], e[16], e[15:8], e[7:1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 2'b00;
    data0 = 32'h0; data1 = 32'h0;
    blank0 = 8'h00; blank1 = 8'h00; dp0 = 8'h00; dp1 = 8'h00;

    // Reset, then idle with random data on the buses.
    cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      data0 = $urandom; data1 = $urandom;
      cyc(1);
    end

    // Single requester with a fixed message.
    req = 2'b01; data0 = 32'h2021_1028;
    cyc(70);

    // Contention from idle, alternating ownership.
    rst = 1'b1; req = 2'b00; cyc(2); rst = 1'b0;
    req = 2'b11; data0 = $urandom; data1 = $urandom;
    for (int i = 0; i < 260; i++) begin
      if (i % 17 == 0) begin data0 = $urandom; data1 = $urandom; end
      cyc(1);
    end

    // Owner release mid-frame with data changing afterwards.
    rst = 1'b1; req = 2'b00; cyc(2); rst = 1'b0;
    req = 2'b01; data0 = 32'h1234_5678;
    cyc(40);
    req = 2'b00;
    cyc(5);
    data0 = 32'h9abc_def0;
    cyc(30);

    // Blank and decimal point.
    rst = 1'b1; cyc(2); rst = 1'b0;
    req = 2'b01; data0 = 32'hfedc_ba98; blank0 = 8'h0f; dp0 = 8'h10;
    cyc(40);
    blank0 = 8'h00; dp0 = 8'h00;

    // Reset mid-frame, then contention must favour requester 0 again.
    rst = 1'b1; req = 2'b00; cyc(2); rst = 1'b0;
    req = 2'b10; cyc(50);
    req = 2'b01; cyc(10);
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 2'b11; cyc(40);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) req = 2'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        data0 = $urandom; data1 = $urandom;
        blank0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        blank1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        dp0 = 8'($urandom); dp1 = 8'($urandom);
      end
      rst = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0;

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
